// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// General-purpose register file with a per-register busy scoreboard.
//
// Issue logic reserves a destination register when a multi-cycle producer is
// dispatched (rsv_en/rsv_addr). The writeback path releases it through the
// normal write port. Source operands that still have an outstanding producer
// are flagged on rs_busy/rt_busy, and hazard combines them with the operand
// "used" qualifiers so the control unit can stall in the same cycle.
//
// Optional features:
//   ZERO_REG=1 : register 0 reads as 0, and writes/reservations to it are
//                dropped.
//   BYPASS=1   : same-cycle write data is forwarded to the read ports, and a
//                same-cycle writeback clears the reported busy flag.
// With BYPASS=0 and ZERO_REG=0 the block behaves as a plain register file.
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   address width, depth is 2**ADDR_W
//   ZERO_REG hardwired zero register enable
//   BYPASS   write-through read bypass enable
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset (clears data, busy and count)
//   we/rd/wd     write enable, write address, write data
//   rs/rt        read addresses for ports 1 and 2
//   rs_used      current instruction consumes rs
//   rt_used      current instruction consumes rt
//   rsv_en       reserve the register at rsv_addr
//   rsv_addr     register to reserve
//   rd1/rd2      combinational read data
//   rs_busy      rs has an outstanding producer
//   rt_busy      rt has an outstanding producer
//   hazard       combinational stall request
//   pending_cnt  number of registers currently busy
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              hazard,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BYP   = (BYPASS != 0);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [CNT_W-1:0]  pending_q;
  logic [CNT_W-1:0]  pending_d;

  // ---------------------------------------------------------------------------
  // Effective write / reserve after the zero-register filter
  // ---------------------------------------------------------------------------
  logic wr_ok;
  logic rsv_ok;
  logic set_evt;
  logic clr_evt;

  assign wr_ok  = we     && !(ZR && (rd == '0));
  assign rsv_ok = rsv_en && !(ZR && (rsv_addr == '0));

  // A register becomes busy only if it was idle; re-reserving a busy register
  // is not a count event.
  assign set_evt = rsv_ok && !busy_q[rsv_addr];

  // A writeback releases a busy register, unless a new producer is reserved
  // for the same register in the same cycle (the reservation wins).
  assign clr_evt = wr_ok && busy_q[rd] && !(rsv_ok && (rsv_addr == rd));

  // ---------------------------------------------------------------------------
  // Next-state for busy bits and pending count
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[rd] = 1'b0;
    end
    // Applied after the write so that reserve wins on an address collision.
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  // Incremental count: at most one set and one clear per cycle, so the net
  // change is always -1, 0 or +1.
  always_comb begin
    pending_d = pending_q;
    unique case ({set_evt, clr_evt})
      2'b10:   pending_d = pending_q + CNT_W'(1);
      2'b01:   pending_d = pending_q - CNT_W'(1);
      default: pending_d = pending_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[rd] <= wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: zero register first, then bypass, then array
  // ---------------------------------------------------------------------------
  logic rs_fwd;
  logic rt_fwd;

  assign rs_fwd = BYP && we && (rd == rs);
  assign rt_fwd = BYP && we && (rd == rt);

  always_comb begin
    rd1 = regs_q[rs];
    if (ZR && (rs == '0)) begin
      rd1 = '0;
    end else if (rs_fwd) begin
      rd1 = wd;
    end
  end

  always_comb begin
    rd2 = regs_q[rt];
    if (ZR && (rt == '0)) begin
      rd2 = '0;
    end else if (rt_fwd) begin
      rd2 = wd;
    end
  end

  // ---------------------------------------------------------------------------
  // Busy / hazard: a forwarded writeback resolves the hazard in-cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    rs_busy = busy_q[rs] && !rs_fwd;
    if (ZR && (rs == '0)) begin
      rs_busy = 1'b0;
    end
  end

  always_comb begin
    rt_busy = busy_q[rt] && !rt_fwd;
    if (ZR && (rt == '0)) begin
      rt_busy = 1'b0;
    end
  end

  assign hazard      = (rs_used && rs_busy) || (rt_used && rt_busy);
  assign pending_cnt = pending_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_scoreboard.
// Two instances share the same stimulus:
//   dut_a : defaults (ZERO_REG=1, BYPASS=1)
//   dut_b : plain register file (ZERO_REG=0, BYPASS=0)
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [2:0] rd;
  logic [7:0] wd;
  logic [2:0] rs;
  logic [2:0] rt;
  logic       rs_used;
  logic       rt_used;
  logic       rsv_en;
  logic [2:0] rsv_addr;

  logic [7:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic       a_rs_busy, a_rt_busy, a_hazard;
  logic       b_rs_busy, b_rt_busy, b_hazard;
  logic [3:0] a_pending, b_pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int pa;
    int pb;
  } exp_t;
  exp_t sbq[$];

  // Reference state for the random run: index 0 = dut_a, 1 = dut_b
  logic [7:0] m_regs [2][8];
  bit         m_busy [2][8];

  regfile_scoreboard #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .rd(rd), .wd(wd), .rs(rs), .rt(rt),
    .rs_used(rs_used), .rt_used(rt_used), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd1(a_rd1), .rd2(a_rd2), .rs_busy(a_rs_busy), .rt_busy(a_rt_busy),
    .hazard(a_hazard), .pending_cnt(a_pending)
  );

  regfile_scoreboard #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .rd(rd), .wd(wd), .rs(rs), .rt(rt),
    .rs_used(rs_used), .rt_used(rt_used), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd1(b_rd1), .rd2(b_rd2), .rs_busy(b_rs_busy), .rt_busy(b_rt_busy),
    .hazard(b_hazard), .pending_cnt(b_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1);
  end

  task automatic idle();
    we = 0; rd = 0; wd = 0; rs = 0; rt = 0;
    rs_used = 0; rt_used = 0; rsv_en = 0; rsv_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle();
    rs = 3; rs_used = 1;
    #2;
    checks++; if (a_pending !== 4'd0) begin errors++; $display("FAIL reset_a_pending got %0d want 0", a_pending); end
    checks++; if (b_pending !== 4'd0) begin errors++; $display("FAIL reset_b_pending got %0d want 0", b_pending); end
    checks++; if (a_rd1 !== 8'h00) begin errors++; $display("FAIL reset_a_rd1 got %h want 00", a_rd1); end
    checks++; if (a_hazard !== 1'b0) begin errors++; $display("FAIL reset_a_hazard got %b want 0", a_hazard); end
    @(negedge clk);
    rst_n = 1;
    idle();
    we = 1; rd = 3; wd = 8'hA5; rsv_en = 1; rsv_addr = 4;
    tick();
    idle(); rs = 3;
    #1;
    checks++; if (a_rd1 !== 8'hA5) begin errors++; $display("FAIL pre_reset_a_rd1 got %h want a5", a_rd1); end
    checks++; if (a_pending !== 4'd1) begin errors++; $display("FAIL pre_reset_a_pending got %0d want 1", a_pending); end
    rst_n = 0;
    #1;
    checks++; if (a_rd1 !== 8'h00) begin errors++; $display("FAIL async_reset_a_rd1 got %h want 00", a_rd1); end
    checks++; if (b_rd1 !== 8'h00) begin errors++; $display("FAIL async_reset_b_rd1 got %h want 00", b_rd1); end
    checks++; if (a_pending !== 4'd0) begin errors++; $display("FAIL async_reset_a_pending got %0d want 0", a_pending); end
    checks++; if (b_pending !== 4'd0) begin errors++; $display("FAIL async_reset_b_pending got %0d want 0", b_pending); end
    #1;
    rst_n = 1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_bypass();
    @(negedge clk);
    idle(); we = 1; rd = 5; wd = 8'h11;
    tick();
    @(negedge clk);
    idle(); we = 1; rd = 5; wd = 8'h7E; rs = 5;
    #1;
    checks++; if (a_rd1 !== 8'h7E) begin errors++; $display("FAIL bypass_a_rd1 got %h want 7e", a_rd1); end
    checks++; if (b_rd1 !== 8'h11) begin errors++; $display("FAIL nobypass_b_rd1 got %h want 11", b_rd1); end
    tick();
    idle(); rs = 5; rt = 5;
    #1;
    checks++; if (b_rd1 !== 8'h7E) begin errors++; $display("FAIL nobypass_next_b_rd1 got %h want 7e", b_rd1); end
    checks++; if (a_rd2 !== 8'h7E) begin errors++; $display("FAIL bypass_next_a_rd2 got %h want 7e", a_rd2); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_zero_reg();
    @(negedge clk);
    idle(); we = 1; rd = 0; wd = 8'hFF; rsv_en = 1; rsv_addr = 0; rs = 0;
    #1;
    checks++; if (a_rd1 !== 8'h00) begin errors++; $display("FAIL zero_inflight_a_rd1 got %h want 00", a_rd1); end
    tick();
    idle(); rs = 0; rs_used = 1;
    #1;
    checks++; if (a_rd1 !== 8'h00) begin errors++; $display("FAIL zero_a_rd1 got %h want 00", a_rd1); end
    checks++; if (a_rs_busy !== 1'b0) begin errors++; $display("FAIL zero_a_rs_busy got %b want 0", a_rs_busy); end
    checks++; if (a_pending !== 4'd0) begin errors++; $display("FAIL zero_a_pending got %0d want 0", a_pending); end
    checks++; if (b_rd1 !== 8'hFF) begin errors++; $display("FAIL nozero_b_rd1 got %h want ff", b_rd1); end
    checks++; if (b_pending !== 4'd1) begin errors++; $display("FAIL nozero_b_pending got %0d want 1", b_pending); end
    checks++; if (b_hazard !== 1'b1) begin errors++; $display("FAIL nozero_b_hazard got %b want 1", b_hazard); end
    @(negedge clk);
    idle(); we = 1; rd = 0; wd = 8'hFF;
    tick();
    idle();
    #1;
    checks++; if (b_pending !== 4'd0) begin errors++; $display("FAIL nozero_release_b_pending got %0d want 0", b_pending); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_hazard();
    @(negedge clk);
    idle(); rsv_en = 1; rsv_addr = 2;
    tick();
    @(negedge clk);
    idle(); rsv_en = 1; rsv_addr = 4;
    tick();
    idle();
    #1;
    checks++; if (a_pending !== 4'd2) begin errors++; $display("FAIL hazard_a_pending got %0d want 2", a_pending); end
    checks++; if (b_pending !== 4'd2) begin errors++; $display("FAIL hazard_b_pending got %0d want 2", b_pending); end
    @(negedge clk);
    rs = 2; rs_used = 1; rt = 4; rt_used = 0;
    #1;
    checks++; if (a_hazard !== 1'b1) begin errors++; $display("FAIL hazard_rs_a got %b want 1", a_hazard); end
    checks++; if (a_rt_busy !== 1'b1) begin errors++; $display("FAIL hazard_rt_busy_a got %b want 1", a_rt_busy); end
    rs_used = 0;
    #1;
    checks++; if (a_hazard !== 1'b0) begin errors++; $display("FAIL hazard_rt_unused_a got %b want 0", a_hazard); end
    rt_used = 1;
    #1;
    checks++; if (b_hazard !== 1'b1) begin errors++; $display("FAIL hazard_rt_used_b got %b want 1", b_hazard); end
    @(negedge clk);
    idle(); we = 1; rd = 2; wd = 8'h33; rs = 2; rs_used = 1;
    #1;
    checks++; if (a_hazard !== 1'b0) begin errors++; $display("FAIL hazard_wb_bypass_a got %b want 0", a_hazard); end
    checks++; if (b_hazard !== 1'b1) begin errors++; $display("FAIL hazard_wb_nobypass_b got %b want 1", b_hazard); end
    checks++; if (a_rd1 !== 8'h33) begin errors++; $display("FAIL hazard_wb_a_rd1 got %h want 33", a_rd1); end
    tick();
    idle();
    #1;
    checks++; if (a_pending !== 4'd1) begin errors++; $display("FAIL hazard_after_wb_a_pending got %0d want 1", a_pending); end
    checks++; if (b_pending !== 4'd1) begin errors++; $display("FAIL hazard_after_wb_b_pending got %0d want 1", b_pending); end
    @(negedge clk);
    idle(); we = 1; rd = 4; wd = 8'h44;
    tick();
    idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_write_reserve();
    @(negedge clk);
    idle(); rsv_en = 1; rsv_addr = 6;
    tick();
    @(negedge clk);
    idle(); we = 1; rd = 6; wd = 8'h5A; rsv_en = 1; rsv_addr = 6;
    tick();
    idle(); rs = 6; rt = 6;
    #1;
    checks++; if (a_pending !== 4'd1) begin errors++; $display("FAIL wr_rsv_a_pending got %0d want 1", a_pending); end
    checks++; if (a_rs_busy !== 1'b1) begin errors++; $display("FAIL wr_rsv_a_rs_busy got %b want 1", a_rs_busy); end
    checks++; if (a_rd1 !== 8'h5A) begin errors++; $display("FAIL wr_rsv_a_rd1 got %h want 5a", a_rd1); end
    checks++; if (b_rd2 !== 8'h5A) begin errors++; $display("FAIL wr_rsv_b_rd2 got %h want 5a", b_rd2); end
    @(negedge clk);
    idle(); rsv_en = 1; rsv_addr = 6;
    tick();
    idle();
    #1;
    checks++; if (a_pending !== 4'd1) begin errors++; $display("FAIL rersv_a_pending got %0d want 1", a_pending); end
    checks++; if (b_pending !== 4'd1) begin errors++; $display("FAIL rersv_b_pending got %0d want 1", b_pending); end
    @(negedge clk);
    idle(); we = 1; rd = 6; wd = 8'h66;
    tick();
    idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_full();
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      idle(); rsv_en = 1; rsv_addr = 3'(i);
      tick();
    end
    idle();
    #1;
    checks++; if (a_pending !== 4'd7) begin errors++; $display("FAIL full_a_pending got %0d want 7", a_pending); end
    checks++; if (b_pending !== 4'd7) begin errors++; $display("FAIL full_b_pending got %0d want 7", b_pending); end
    @(negedge clk);
    idle(); rsv_en = 1; rsv_addr = 0;
    tick();
    idle();
    #1;
    checks++; if (a_pending !== 4'd7) begin errors++; $display("FAIL full_r0_a_pending got %0d want 7", a_pending); end
    checks++; if (b_pending !== 4'd8) begin errors++; $display("FAIL full_r0_b_pending got %0d want 8", b_pending); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle(); we = 1; rd = 3'(i); wd = 8'(i * 3);
      tick();
    end
    idle();
    #1;
    checks++; if (a_pending !== 4'd0) begin errors++; $display("FAIL drain_a_pending got %0d want 0", a_pending); end
    checks++; if (b_pending !== 4'd0) begin errors++; $display("FAIL drain_b_pending got %0d want 0", b_pending); end
  endtask

  // ---------------------------------------------------------------------------
  function automatic logic [7:0] exp_read(int c, logic [2:0] a);
    if (c == 0 && a == 3'd0) return 8'h00;
    if (c == 0 && we && rd == a) return wd;
    return m_regs[c][a];
  endfunction

  function automatic bit exp_busy(int c, logic [2:0] a);
    if (c == 0 && a == 3'd0) return 1'b0;
    if (c == 0 && we && rd == a) return 1'b0;
    return m_busy[c][a];
  endfunction

  function automatic int popcnt(int c);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_busy[c][i]);
    return n;
  endfunction

  task automatic test_random();
    exp_t e;
    bit   hz;
    @(negedge clk);
    idle();
    rst_n = 0;
    #1;
    rst_n = 1;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[c][i] = 8'h00;
        m_busy[c][i] = 1'b0;
      end
    end
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      we       = ($urandom_range(0, 1) == 1);
      rd       = 3'($urandom_range(0, 7));
      wd       = 8'($urandom);
      rs       = 3'($urandom_range(0, 7));
      rt       = 3'($urandom_range(0, 7));
      rs_used  = ($urandom_range(0, 1) == 1);
      rt_used  = ($urandom_range(0, 1) == 1);
      rsv_en   = ($urandom_range(0, 2) != 0);
      rsv_addr = 3'($urandom_range(0, 7));
      #1;
      checks++; if (a_rd1 !== exp_read(0, rs)) begin errors++; $display("FAIL rand_a_rd1 cyc %0d got %h want %h", n, a_rd1, exp_read(0, rs)); end
      checks++; if (a_rd2 !== exp_read(0, rt)) begin errors++; $display("FAIL rand_a_rd2 cyc %0d got %h want %h", n, a_rd2, exp_read(0, rt)); end
      checks++; if (b_rd1 !== exp_read(1, rs)) begin errors++; $display("FAIL rand_b_rd1 cyc %0d got %h want %h", n, b_rd1, exp_read(1, rs)); end
      hz = (rs_used && exp_busy(0, rs)) || (rt_used && exp_busy(0, rt));
      checks++; if (a_hazard !== hz) begin errors++; $display("FAIL rand_a_hazard cyc %0d got %b want %b", n, a_hazard, hz); end
      hz = (rs_used && exp_busy(1, rs)) || (rt_used && exp_busy(1, rt));
      checks++; if (b_hazard !== hz) begin errors++; $display("FAIL rand_b_hazard cyc %0d got %b want %b", n, b_hazard, hz); end
      // advance the reference state to what follows this edge
      for (int c = 0; c < 2; c++) begin
        if (we && !(c == 0 && rd == 3'd0)) begin
          m_regs[c][rd] = wd;
          m_busy[c][rd] = 1'b0;
        end
        if (rsv_en && !(c == 0 && rsv_addr == 3'd0)) begin
          m_busy[c][rsv_addr] = 1'b1;
        end
      end
      e.pa = popcnt(0);
      e.pb = popcnt(1);
      sbq.push_back(e);
      tick();
      e = sbq.pop_front();
      checks++; if (a_pending !== 4'(e.pa)) begin errors++; $display("FAIL rand_a_pending cyc %0d got %0d want %0d", n, a_pending, e.pa); end
      checks++; if (b_pending !== 4'(e.pb)) begin errors++; $display("FAIL rand_b_pending cyc %0d got %0d want %0d", n, b_pending, e.pb); end
    end
    idle();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_hazard();
    test_write_reserve();
    test_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file for the single-cycle CPU datapath, with write-through read bypass, an optional hardwired zero register and a per-register busy scoreboard. Issue logic reserves a destination register when a multi-cycle producer is dispatched, and the writeback path releases it. The block reports source-operand hazards so the control unit can stall. It replaces the fixed 8x8 register file and is a drop-in superset of it when `BYPASS=0` and `ZERO_REG=0`.

## Interface
- `DATA_W`, default 8: register width in bits.
- `ADDR_W`, default 3: address width; depth is `2**ADDR_W`.
- `ZERO_REG`, default 1: when 1, register 0 always reads 0, and writes and reservations to it are ignored.
- `BYPASS`, default 1: when 1, same-cycle write data is forwarded to the read ports.
- `clk`, in, 1: sole clock. All state updates on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `we`, in, 1: write enable.
- `rd`, in, `ADDR_W`: write address.
- `wd`, in, `DATA_W`: write data.
- `rs`, in, `ADDR_W`: read address, port 1.
- `rt`, in, `ADDR_W`: read address, port 2.
- `rs_used`, in, 1: the current instruction consumes `rs`.
- `rt_used`, in, 1: the current instruction consumes `rt`.
- `rsv_en`, in, 1: reserve a destination register.
- `rsv_addr`, in, `ADDR_W`: register to reserve.
- `rd1`, out, `DATA_W`: read data, port 1.
- `rd2`, out, `DATA_W`: read data, port 2.
- `rs_busy`, out, 1: `rs` has an outstanding producer.
- `rt_busy`, out, 1: `rt` has an outstanding producer.
- `hazard`, out, 1: stall request.
- `pending_cnt`, out, `ADDR_W+1`: number of registers currently busy.

## Operation
- **State:** `regs[0..2**ADDR_W-1]` of `DATA_W` bits, `busy[0..2**ADDR_W-1]` of 1 bit each, and `pending_cnt`.
- **Reset:** while `rst_n`=0, immediately and regardless of `clk`:
  - all `regs` = 0;
  - all `busy` = 0;
  - `pending_cnt` = 0.
  - Consequently `rd1`=`rd2`=0 unless bypass is active, and `rs_busy`=`rt_busy`=`hazard`=0.
  - Reset asserted mid-operation discards all reservations and pending writes.
- **Write:** at the rising edge with `we`=1, `regs[rd]` <= `wd` and `busy[rd]` <= 0. Exception: when `ZERO_REG`=1 and `rd`=0, nothing is updated.
- **Reserve:** at the rising edge with `rsv_en`=1, `busy[rsv_addr]` <= 1. Ignored when `ZERO_REG`=1 and `rsv_addr`=0.
- **Write and reserve to the same register in one cycle:** the reserve wins, so `busy` ends at 1 (a new producer has been issued). The data write still occurs.
- **Reserving an already-busy register:** `busy` stays 1 and `pending_cnt` is unchanged.
- **`pending_cnt`:** always equals the popcount of `busy`. Update it incrementally from the per-cycle set/clear events (net change is -1, 0 or +1). It can never exceed `2**ADDR_W`, or `2**ADDR_W-1` with `ZERO_REG`=1.
- **Read (combinational), `rd1` from `rs`:**
  - If `ZERO_REG`=1 and `rs`=0: 0.
  - Else if `BYPASS`=1, `we`=1 and `rd`=`rs`: `wd`.
  - Else: `regs[rs]`.
  - `rd2` from `rt` follows the same rules.
- **Busy (combinational):**
  - `rs_busy` = `busy[rs]` AND NOT(`BYPASS` AND `we` AND `rd`=`rs`). A same-cycle writeback resolves the hazard only when bypass is enabled.
  - Forced to 0 when `ZERO_REG`=1 and `rs`=0.
  - `rt_busy` follows the same rules.
- **Hazard:** `hazard` = (`rs_used` AND `rs_busy`) OR (`rt_used` AND `rt_busy`). The block does not register or hold the hazard; the control unit acts on it in the same cycle.

## Timing
- Write latency: 1 cycle to the array.
- With `BYPASS`=1 the written value is visible on `rd1`/`rd2` in the same cycle as `we`. With `BYPASS`=0 it is visible from the cycle after the edge.
- Reserve latency: `busy` and `*_busy` rise in the cycle after the `rsv_en` edge. `pending_cnt` updates on that same edge.
- Combinational paths:
  - `rs`/`rt`/`rd`/`we`/`wd` to `rd1`/`rd2`;
  - the same inputs to `*_busy` and `hazard`.
  - There are no combinational paths from `rsv_*`.
- Write/reserve address wrap: none. All addresses are in range by construction.

## Test plan
1. **Reset clears state.** Write 0xA5 to r3, then pulse `rst_n` low between clock edges → `rd1`(`rs`=3)=0 immediately and `pending_cnt`=0.
2. **Bypass on/off.**
   - `BYPASS`=1: r5=0x11; in one cycle `we`=1, `rd`=5, `wd`=0x7E, `rs`=5 → `rd1`=0x7E in that cycle.
   - `BYPASS`=0: same stimulus → `rd1`=0x11 that cycle and 0x7E next cycle.
3. **Zero register.** `ZERO_REG`=1: write 0xFF to r0 and reserve r0 → `rd1`(`rs`=0)=0, `rs_busy`=0, `pending_cnt`=0. With `ZERO_REG`=0, r0 reads 0xFF.
4. **Scoreboard hazard.**
   - Reserve r2, then r4 → `pending_cnt`=2.
   - `rs`=2 with `rs_used`=1 → `hazard`=1.
   - `rt`=4 with `rt_used`=0 → that port contributes nothing.
   - Write r2 → `hazard`=0 in the write cycle (`BYPASS`=1) and `pending_cnt`=1 afterwards.
5. **Simultaneous write and reserve to r6.**
   - `busy[6]`=1, `we`=1 and `rsv_en`=1 in the same cycle → r6 takes `wd`, `busy[6]` stays 1, `pending_cnt` unchanged.
   - Reserve an already-busy r6 again → `pending_cnt` unchanged.
6. **Full scoreboard.** `ADDR_W`=3, `ZERO_REG`=1: reserve r1..r7 → `pending_cnt`=7. Write all seven → `pending_cnt`=0. A random write/reserve run checks `pending_cnt` = popcount of `busy` on every cycle.
